// File: rtl/reg_access_pkg.sv
// rtl/reg_access_pkg.sv - shared types for the storage register command sequencer
package reg_access_pkg;

    localparam int ST_DW = 16;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ISSUE,
        RD_CAPTURE,
        RESP
    } state_t;

    typedef struct packed {
        logic             op;
        logic [ST_DW-1:0] data;
    } cmd_t;

endpackage

// File: rtl/reg_access_ctrl_if.sv
// rtl/reg_access_ctrl_if.sv - host command and response handshake channels
interface reg_access_ctrl_if #(
    parameter int DW = 16
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_write, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/reg_cmd_fifo.sv
// rtl/reg_cmd_fifo.sv - synchronous command FIFO with wrap-bit full/empty detection
module reg_cmd_fifo
    import reg_access_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  cmd_t push_data,
    input  logic pop,
    output cmd_t head,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    cmd_t          mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    // Pointers share low bits when full or empty; the extra top bit tells them apart.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Pointer advance; pushes while full and pops while empty are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Entry storage; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end
endmodule

// File: rtl/reg_access_ctrl.sv
// rtl/reg_access_ctrl.sv - sequences host commands onto the 16-bit storage register
module reg_access_ctrl
    import reg_access_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = ST_DW
) (
    input  logic                    clk,
    input  logic                    reset,
    reg_access_ctrl_if.slave        host,
    output logic [DW-1:0]           st_in,
    output logic                    st_read_write,
    input  logic [DW-1:0]           st_out,
    output logic                    busy,
    output logic [15:0]             wr_count,
    output logic [15:0]             rd_count
);
    state_t        state;
    state_t        next_state;
    cmd_t          push_data;
    cmd_t          head;
    logic          full;
    logic          empty;
    logic          pop;
    logic [DW-1:0] st_in_q;
    logic [DW-1:0] rsp_data_q;
    logic [15:0]   wr_count_q;
    logic [15:0]   rd_count_q;

    assign push_data.op   = host.cmd_write;
    assign push_data.data = host.cmd_wdata;
    assign pop            = (state == IDLE) && !empty;

    reg_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (host.cmd_valid),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    assign host.cmd_ready = !full;
    assign host.rsp_data  = rsp_data_q;
    assign st_in          = st_in_q;
    assign busy           = (state != IDLE) || !empty;
    assign wr_count       = wr_count_q;
    assign rd_count       = rd_count_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and state-decoded storage/response strobes.
    always_comb begin
        next_state     = state;
        st_read_write  = 1'b0;
        host.rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    next_state = (head.op == OP_READ) ? RD_ISSUE : WRITE;
                end
            end
            WRITE: begin
                st_read_write = 1'b1;
                next_state    = IDLE;
            end
            RD_ISSUE:   next_state = RD_CAPTURE;
            RD_CAPTURE: next_state = RESP;
            RESP: begin
                host.rsp_valid = 1'b1;
                if (host.rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Write data is latched at pop so it is already stable for the whole WRITE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_in_q    <= '0;
            rsp_data_q <= '0;
            wr_count_q <= '0;
            rd_count_q <= '0;
        end else begin
            if (pop && head.op == OP_WRITE) begin
                st_in_q <= head.data;
            end
            if (state == RD_CAPTURE) begin
                rsp_data_q <= st_out;
            end
            if (state == WRITE) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
            if (state == RESP && host.rsp_ready) begin
                rd_count_q <= rd_count_q + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_reg_access_ctrl.sv
// tb/tb_reg_access_ctrl.sv - directed vector bench for reg_access_ctrl
module tb_reg_access_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] st_in;
    logic        st_read_write;
    logic [15:0] st_out = 16'h0;
    logic [15:0] st_mem = 16'h0;
    logic        busy;
    logic [15:0] wr_count;
    logic [15:0] rd_count;

    int total = 0;
    int bad   = 0;

    logic [15:0] wq [$];

    typedef struct {
        logic        wr;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [10];

    reg_access_ctrl_if #(.DW(16)) host_if ();

    reg_access_ctrl #(.DEPTH(4), .DW(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .host          (host_if),
        .st_in         (st_in),
        .st_read_write (st_read_write),
        .st_out        (st_out),
        .busy          (busy),
        .wr_count      (wr_count),
        .rd_count      (rd_count)
    );

    always #5 clk = ~clk;

    // Behavioural storage register: captures on write, presents data on read.
    always @(posedge clk) begin
        if (st_read_write) st_mem <= st_in;
        else               st_out <= st_mem;
    end

    // Record every write driven to storage.
    always @(negedge clk) begin
        if (st_read_write) wq.push_back(st_in);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push_cmd(input logic w, input logic [15:0] d);
        int n = 0;
        while (!host_if.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", host_if.cmd_ready, 1);
        host_if.cmd_valid = 1'b1;
        host_if.cmd_write = w;
        host_if.cmd_wdata = d;
        @(negedge clk);
        host_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name, input logic [15:0] exp);
        int n = 0;
        while (!host_if.rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, host_if.rsp_valid, 1);
        check(name, host_if.rsp_data, exp);
        host_if.rsp_ready = 1'b1;
        @(negedge clk);
        host_if.rsp_ready = 1'b0;
    endtask

    initial begin
        int          resp_seen;
        int          wr_seen;
        logic [15:0] wr_base;

        vecs[0] = '{1'b1, 16'h1234, 16'h0000};
        vecs[1] = '{1'b0, 16'h0000, 16'h1234};
        vecs[2] = '{1'b1, 16'h0001, 16'h0000};
        vecs[3] = '{1'b0, 16'h0000, 16'h0001};
        vecs[4] = '{1'b1, 16'h0002, 16'h0000};
        vecs[5] = '{1'b0, 16'h0000, 16'h0002};
        vecs[6] = '{1'b1, 16'h0003, 16'h0000};
        vecs[7] = '{1'b0, 16'h0000, 16'h0003};
        vecs[8] = '{1'b1, 16'h0004, 16'h0000};
        vecs[9] = '{1'b0, 16'h0000, 16'h0004};

        host_if.cmd_valid = 1'b0;
        host_if.cmd_write = 1'b0;
        host_if.cmd_wdata = 16'h0;
        host_if.rsp_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_cmd_ready", host_if.cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", host_if.rsp_valid, 0);
        check("rst_rsp_data", host_if.rsp_data, 0);
        check("rst_st_in", st_in, 0);
        check("rst_st_rw", st_read_write, 0);
        check("rst_wr_count", wr_count, 0);
        check("rst_rd_count", rd_count, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single write, cycle accurate: accepted E0, WRITE only during cycle 2.
        host_if.cmd_valid = 1'b1;
        host_if.cmd_write = 1'b1;
        host_if.cmd_wdata = 16'hA5A5;
        @(negedge clk);
        host_if.cmd_valid = 1'b0;
        check("w_c1_rw", st_read_write, 0);
        check("w_c1_busy", busy, 1);
        @(negedge clk);
        check("w_c2_rw", st_read_write, 1);
        check("w_c2_in", st_in, 16'hA5A5);
        @(negedge clk);
        check("w_c3_rw", st_read_write, 0);
        check("w_c3_in_hold", st_in, 16'hA5A5);
        check("w_c3_wr_count", wr_count, 1);
        check("w_c3_busy", busy, 0);

        // Table: back-to-back write/read pairs, reads return the preceding write.
        for (int i = 0; i < 10; i++) begin
            push_cmd(vecs[i].wr, vecs[i].data);
            if (!vecs[i].wr) wait_rsp($sformatf("vec%0d", i), vecs[i].exp);
        end
        repeat (4) @(negedge clk);
        check("tbl_wr_count", wr_count, 6);
        check("tbl_rd_count", rd_count, 5);

        // Read latency: accepted E0, rsp_valid first visible in cycle 4.
        host_if.cmd_valid = 1'b1;
        host_if.cmd_write = 1'b0;
        @(negedge clk);
        host_if.cmd_valid = 1'b0;
        @(negedge clk);
        check("r_c2_rw", st_read_write, 0);
        @(negedge clk);
        check("r_c3_valid", host_if.rsp_valid, 0);
        @(negedge clk);
        check("r_c4_valid", host_if.rsp_valid, 1);
        check("r_c4_data", host_if.rsp_data, 16'h0004);
        host_if.rsp_ready = 1'b1;
        @(negedge clk);
        host_if.rsp_ready = 1'b0;
        check("r_rd_count", rd_count, 6);
        check("r_idle_busy", busy, 0);

        // Response stall while the FIFO fills with writes.
        wr_base = wr_count;
        push_cmd(1'b0, 16'h0);
        begin
            int n = 0;
            while (!host_if.rsp_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check("stall_valid", host_if.rsp_valid, 1);
        for (int k = 0; k < 4; k++) push_cmd(1'b1, 16'h0011 + 16'(k));
        check("stall_full", host_if.cmd_ready, 0);
        host_if.cmd_valid = 1'b1;
        host_if.cmd_write = 1'b1;
        host_if.cmd_wdata = 16'h0099;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("stall_data%0d", k), host_if.rsp_data, 16'h0004);
            check($sformatf("stall_rdy%0d", k), host_if.cmd_ready, 0);
        end
        host_if.cmd_valid = 1'b0;
        check("stall_still_valid", host_if.rsp_valid, 1);
        wq.delete();
        host_if.rsp_ready = 1'b1;
        @(negedge clk);
        host_if.rsp_ready = 1'b0;
        repeat (12) @(negedge clk);
        check("drain_count", wq.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < wq.size()) check($sformatf("drain%0d", k), wq[k], 16'h0011 + 16'(k));
        end
        check("drain_wr_count", wr_count, wr_base + 16'd4);
        push_cmd(1'b0, 16'h0);
        wait_rsp("drain_readback", 16'h0014);

        // Reset during RD_CAPTURE with a queued write behind the read.
        host_if.cmd_valid = 1'b1;
        host_if.cmd_write = 1'b0;
        @(negedge clk);
        host_if.cmd_write = 1'b1;
        host_if.cmd_wdata = 16'h0066;
        @(negedge clk);
        host_if.cmd_valid = 1'b0;
        @(negedge clk);
        check("rc_busy_before", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check("rc_rsp_valid", host_if.rsp_valid, 0);
        check("rc_busy", busy, 0);
        check("rc_cmd_ready", host_if.cmd_ready, 1);
        check("rc_wr_count", wr_count, 0);
        check("rc_rd_count", rd_count, 0);
        check("rc_rsp_data", host_if.rsp_data, 0);
        check("rc_st_in", st_in, 0);
        reset = 1'b0;
        resp_seen = 0;
        wr_seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (host_if.rsp_valid) resp_seen++;
            if (st_read_write) wr_seen++;
        end
        check("rc_no_resp", resp_seen, 0);
        check("rc_no_write", wr_seen, 0);

        // Counter wrap: preload near the top, then three real writes.
        force dut.wr_count_q = 16'hFFFD;
        @(negedge clk);
        release dut.wr_count_q;
        push_cmd(1'b1, 16'h0101);
        repeat (2) @(negedge clk);
        check("wrap_fffe", wr_count, 16'hFFFE);
        push_cmd(1'b1, 16'h0102);
        repeat (2) @(negedge clk);
        check("wrap_ffff", wr_count, 16'hFFFF);
        push_cmd(1'b1, 16'h0103);
        repeat (2) @(negedge clk);
        check("wrap_zero", wr_count, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
